ides4_deser: RTL
================

# ides4_deser

Single-clock 1:4 DDR input deserializer, the capture stage behind the negedge data flop in our Gowin primitive library. It samples a serial line on both edges of `CLK`, holds an 8-bit bit history, and presents one aligned 4-bit word every two `CLK` cycles with a `VALID` strobe. `CALIB` pulses shift word alignment by one bit (bit-slip) for link training. The model targets Verilator-compatible simulation of Gowin IDES4-style capture.

## Interface
- `INIT`, default 1'b0: reset and initial value driven on every bit of `Q0..Q3`.
- `CLK` input 1: sole clock. Both edges are used.
- `RESETN` input 1: asynchronous, active-low reset.
- `D` input 1: serial DDR data.
- `CALIB` input 1: bit-slip request, level input, edge-detected.
- `Q0` `Q1` `Q2` `Q3` output 1 each: deserialized word. `Q0` holds the oldest bit.
- `VALID` output 1: single-cycle strobe marking a new word on `Q0..Q3`.

## Operation
- The block has one clock and one reset: `CLK` with asynchronous, active-low `RESETN`.
- Sample names: `p_n` is `D` at posedge n. `n_n` is `D` at the negedge following posedge n, captured in a negedge register.
- At posedge n+1, the history `hist[7:0]` shifts in the pair: `hist <= {n_n, p_n, hist[7:2]}`. `hist[7]` holds the newest bit.
- Phase bit `ph` toggles on every posedge and is 0 after reset. A posedge with `ph==1` is a word boundary.
- At a boundary, with slip offset `k` in 0..3, `{Q3,Q2,Q1,Q0} <= hist_next[7-k:4-k]`. Here `hist_next` is the history value being loaded on that same edge.
- Warm-up: a 2-bit counter suppresses the first two boundaries after reset, so outputs hold `INIT` until then. The first `VALID` occurs at the third boundary (posedge 5).
- `VALID` is 1 for exactly the posedge that loads `Q`, otherwise 0. `Q` holds its value between boundaries.
- Bit-slip: `calib_q` registers `CALIB` at each posedge. A rise (`CALIB & ~calib_q`) sets `k <= k+1` mod 4, so 3 wraps to 0.
- A rise coincident with a boundary: the word on that edge uses the old `k`. The new `k` applies from the next boundary.
- `CALIB` held high causes exactly one slip.
- Reset values: `hist`=0, negedge register=0, `p`=0, `ph`=0, warm-up=0, `k`=0, `calib_q`=0, `Q0..Q3`=`INIT`, `VALID`=0.
- Reset mid-operation: all state clears immediately and asynchronously. Warm-up restarts, and no `VALID` is issued until the third boundary after release.

## Timing
- Release `RESETN` before posedge 0. Boundaries fall on posedges 1, 3, 5, …; `VALID` is high on posedges 5, 7, 9, …
- Latency with k=0: `p_m` reaches `Q0` two posedges after it is sampled. `n_{m+1}` reaches `Q3` on the next posedge, half a cycle after capture.
- Each unit of `k` selects a word one bit older, adding one half-cycle of latency.
- Throughput: 4 bits per 2 `CLK` cycles, sustained with no gaps after warm-up.
- The negedge register resets asynchronously with `RESETN` and never updates while `RESETN` is low.

## Configuration
- `IDES4_DESER_CALIB_EN` defined: `calib_q`, the edge detector and `k` are present, and bit-slip works as described above.
- `IDES4_DESER_CALIB_EN` undefined: the `CALIB` port remains but is ignored. `k` is the constant 0, and the word is always `hist_next[7:4]`.

## Test plan
- Reset check: hold `RESETN`=0 with `INIT`=1 and toggle `CLK`. Expect `Q0..Q3`=1,1,1,1 and `VALID`=0. Then pulse `RESETN` low asynchronously between edges: outputs change immediately, with no clock edge.
- Warm-up and cadence: after release, `VALID` is first high at posedge 5, then high every 2nd posedge and low on all others.
- Static pattern: drive `p_n`=1 and `n_n`=0 continuously. Every word is `Q0..Q3`=1,0,1,0.
- Bit-slip: drive `p_n`=1 for even n, 0 for odd n, and `n_n`=0 (1-in-4 bit stream).
  - With k=0, words are `Q0..Q3`=0,0,1,0.
  - After one `CALIB` rise: 0,0,0,1.
  - After 4 total rises: back to 0,0,1,0.
  - With the macro undefined, words stay 0,0,1,0 throughout.
- `CALIB` held high for 10 cycles: exactly one slip. The word changes 0,0,1,0 → 0,0,0,1 once and then stays.
- Coincident slip: a `CALIB` rise on a boundary edge. That edge's word uses the old `k`, and the next boundary shows the slipped word.

Source files
------------

// File: rtl/ides4_deser.sv
// rtl/ides4_deser.sv - 1:4 DDR input deserializer with bit-slip word alignment
//
// Captures serial D on both CLK edges into an 8-bit history. Every second CLK
// cycle it presents one aligned 4-bit word on Q0..Q3 with a one-cycle VALID strobe.
//
// Optional feature macro: IDES4_DESER_CALIB_EN (enables CALIB bit-slip).
//
// Ports:
//   CLK          sole clock, both edges used
//   RESETN       asynchronous active-low reset
//   D            serial DDR data
//   CALIB        bit-slip request (level, rising-edge detected)
//   Q0..Q3       deserialized word, Q0 oldest bit; reset/warm-up value INIT
//   VALID        single-cycle strobe when Q0..Q3 is loaded
module ides4_deser #(
  parameter logic INIT = 1'b0
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic D,
  input  logic CALIB,
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic VALID
);

  logic       n_q;
  logic       p_q;
  logic [7:0] hist_q, hist_d;
  logic       ph_q, ph_d;
  logic [1:0] warm_q, warm_d;
  logic [3:0] word_q, word_d;
  logic       valid_q, valid_d;
  logic [1:0] k;
  logic       load;

  // Falling-edge half of the DDR capture; held cleared while reset is asserted.
  always_ff @(negedge CLK or negedge RESETN) begin
    if (!RESETN) n_q <= 1'b0;
    else         n_q <= D;
  end

`ifdef IDES4_DESER_CALIB_EN
  logic       calib_q;
  logic [1:0] k_q, k_d;
  logic       unused_hist;

  always_comb begin
    k_d = k_q;
    // One slip per CALIB rise; a level held high does not slip again.
    if (CALIB && !calib_q) k_d = k_q + 2'd1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      calib_q <= 1'b0;
      k_q     <= 2'd0;
    end else begin
      calib_q <= CALIB;
      k_q     <= k_d;
    end
  end

  // The word on a boundary uses k before any slip landing on that same edge.
  assign k           = k_q;
  assign unused_hist = ^hist_q[2:0];
`else
  logic unused_calib;

  assign k            = 2'd0;
  assign unused_calib = ^{CALIB, hist_q[5:0]};
`endif

  always_comb begin
    hist_d  = {n_q, p_q, hist_q[7:2]};
    ph_d    = ~ph_q;
    warm_d  = warm_q;
    word_d  = word_q;
    valid_d = 1'b0;
    // ph_q high marks a word boundary; the first two boundaries only advance warm-up.
    load    = ph_q && (warm_q == 2'd2);
    if (ph_q && (warm_q != 2'd2)) warm_d = warm_q + 2'd1;
    if (load) begin
      valid_d = 1'b1;
      // Word is taken from the history being loaded on this edge, k bits older per slip.
      case (k)
        2'd0:    word_d = hist_d[7:4];
        2'd1:    word_d = hist_d[6:3];
        2'd2:    word_d = hist_d[5:2];
        default: word_d = hist_d[4:1];
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      p_q     <= 1'b0;
      hist_q  <= 8'h00;
      ph_q    <= 1'b0;
      warm_q  <= 2'd0;
      word_q  <= {4{INIT}};
      valid_q <= 1'b0;
    end else begin
      p_q     <= D;
      hist_q  <= hist_d;
      ph_q    <= ph_d;
      warm_q  <= warm_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign Q0    = word_q[0];
  assign Q1    = word_q[1];
  assign Q2    = word_q[2];
  assign Q3    = word_q[3];
  assign VALID = valid_q;

endmodule
